// File: rtl/tero_pkg.sv
// Shared state encoding and default sizing for the TERO sweep controller.
package tero_pkg;

    localparam int DEF_SEL_W    = 20;
    localparam int DEF_SMP_LOG2 = 12;
    localparam int DEF_TO_W     = 16;

    localparam logic [7:0] TO_CNT_MAX = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_OSC   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_NEXT  = 3'd4,
        ST_FINI  = 3'd5
    } state_t;

endpackage

// File: rtl/tero_timeout.sv
// Oscillation watchdog: down counter loaded before each oscillation, flags the
// terminal cycle so a stuck ring oscillator still produces a sample.
module tero_timeout
    import tero_pkg::*;
#(
    parameter int W = DEF_TO_W
) (
    input  logic CLK,
    input  logic RST,
    input  logic load,
    input  logic en,
    output logic tc
);

    // Loading 2^W-2 and counting down to zero makes tc fire on the
    // (2^W-1)-th enabled cycle.
    localparam logic [W-1:0] LOAD_VAL = {{(W-1){1'b1}}, 1'b0};

    logic [W-1:0] cnt;

    always_ff @(posedge CLK) begin
        if (RST)
            cnt <= '0;
        else if (load)
            cnt <= LOAD_VAL;
        else if (en && cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign tc = en && (cnt == '0);

endmodule

// File: rtl/tero_sweep_ctrl.sv
// Sweeps the ring-oscillator selection word of a TERO TRNG, collecting a block
// of samples per selection value and pausing while the UART buffer drains.
module tero_sweep_ctrl
    import tero_pkg::*;
#(
    parameter int SEL_W    = DEF_SEL_W,
    parameter int SMP_LOG2 = DEF_SMP_LOG2,
    parameter int TO_W     = DEF_TO_W
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             ABORT,
    input  logic             FIXED,
    input  logic [SEL_W-1:0] SEL_BEGIN,
    input  logic [SEL_W-1:0] SEL_END,
    input  logic             TRNG_OE,
    input  logic             UART_FULL,
    input  logic             UART_EMPTY,
    input  logic             UART_READY,
    output logic             CTR,
    output logic [SEL_W-1:0] RO_SEL,
    output logic             BUSY,
    output logic             DONE,
    output logic [7:0]       TO_CNT
);

    state_t state, state_nxt;

    logic                fixed_q;
    logic [SEL_W-1:0]    sel_end_q;
    logic [SEL_W-1:0]    ro_sel;
    logic [SMP_LOG2-1:0] smp_cnt;
    logic [7:0]          to_cnt;

    logic latch_cfg, take_sample, sel_inc;
    logic to_load, to_en, to_tc;

    tero_timeout #(.W(TO_W)) u_timeout (
        .CLK  (CLK),
        .RST  (RST),
        .load (to_load),
        .en   (to_en),
        .tc   (to_tc)
    );

    always_ff @(posedge CLK) begin
        if (RST)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        latch_cfg   = 1'b0;
        take_sample = 1'b0;
        sel_inc     = 1'b0;
        to_load     = 1'b0;
        to_en       = (state == ST_OSC);
        if (ABORT) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE, ST_FINI: begin
                    if (START) begin
                        latch_cfg = 1'b1;
                        state_nxt = ST_START;
                    end
                end
                ST_START: begin
                    to_load   = 1'b1;
                    state_nxt = ST_OSC;
                end
                ST_OSC: begin
                    if (TRNG_OE || to_tc) begin
                        take_sample = 1'b1;
                        if (UART_FULL)
                            state_nxt = ST_DRAIN;
                        else if (fixed_q)
                            state_nxt = ST_START;
                        else if (&smp_cnt)
                            state_nxt = ST_NEXT;
                        else
                            state_nxt = ST_START;
                    end
                end
                ST_DRAIN: begin
                    // Counter has already advanced; zero means the block just wrapped.
                    if (UART_EMPTY) begin
                        if (fixed_q)
                            state_nxt = ST_START;
                        else if (smp_cnt == '0)
                            state_nxt = ST_NEXT;
                        else
                            state_nxt = ST_START;
                    end
                end
                ST_NEXT: begin
                    if (UART_READY) begin
                        if (ro_sel == sel_end_q) begin
                            state_nxt = ST_FINI;
                        end else begin
                            sel_inc   = 1'b1;
                            state_nxt = ST_START;
                        end
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            fixed_q   <= 1'b0;
            sel_end_q <= '0;
            ro_sel    <= '0;
            smp_cnt   <= '0;
            to_cnt    <= '0;
        end else begin
            if (latch_cfg) begin
                fixed_q   <= FIXED;
                sel_end_q <= SEL_END;
                ro_sel    <= SEL_BEGIN;
                smp_cnt   <= '0;
                to_cnt    <= '0;
            end
            if (take_sample) begin
                smp_cnt <= smp_cnt + 1'b1;
                // A sample arriving on the terminal cycle is genuine, not a timeout.
                if (to_tc && !TRNG_OE && to_cnt != TO_CNT_MAX)
                    to_cnt <= to_cnt + 8'd1;
            end
            if (sel_inc)
                ro_sel <= ro_sel + 1'b1;
        end
    end

    assign CTR    = (state == ST_OSC);
    assign BUSY   = (state != ST_IDLE) && (state != ST_FINI);
    assign DONE   = (state == ST_FINI);
    assign RO_SEL = ro_sel;
    assign TO_CNT = to_cnt;

endmodule

// File: tb/tb_tero_sweep_ctrl.sv
// Scoreboard bench for tero_sweep_ctrl: expected selection words and oscillation
// lengths are queued at stimulus time and popped by an independent monitor.
module tb_tero_sweep_ctrl;

    localparam int SEL_W       = 4;
    localparam int SMP_LOG2    = 2;
    localparam int TO_W        = 4;
    localparam int SMP_PER_SEL = 1 << SMP_LOG2;
    localparam int TO_LEN      = (1 << TO_W) - 1;
    localparam int RUN_BOUND   = 8000;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic             fixed = 1'b0;
    logic [SEL_W-1:0] sel_begin = '0;
    logic [SEL_W-1:0] sel_end = '0;
    logic             trng_oe = 1'b0;
    logic             uart_full = 1'b0;
    logic             uart_empty = 1'b1;
    logic             uart_ready = 1'b1;
    logic             ctr;
    logic [SEL_W-1:0] ro_sel;
    logic             busy;
    logic             done;
    logic [7:0]       to_cnt;

    int errors = 0;
    int checks = 0;
    int sel_q[$];
    int len_q[$];
    bit len_chk = 1'b1;
    bit uart_rand = 1'b0;
    int fixed_delay = 0;
    int to_tally = 0;
    int resp_cyc = 0;
    int resp_target = 0;
    logic ctr_d = 1'b0;
    int len_meas = 0;
    int exp_len = 0;

    tero_sweep_ctrl #(.SEL_W(SEL_W), .SMP_LOG2(SMP_LOG2), .TO_W(TO_W)) dut (
        .CLK        (clk),
        .RST        (rst),
        .START      (start),
        .ABORT      (abort),
        .FIXED      (fixed),
        .SEL_BEGIN  (sel_begin),
        .SEL_END    (sel_end),
        .TRNG_OE    (trng_oe),
        .UART_FULL  (uart_full),
        .UART_EMPTY (uart_empty),
        .UART_READY (uart_ready),
        .CTR        (ctr),
        .RO_SEL     (ro_sel),
        .BUSY       (busy),
        .DONE       (done),
        .TO_CNT     (to_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // TRNG core model: ends each oscillation on a chosen cycle, or withholds the
    // pulse entirely so the watchdog has to end it.
    initial forever begin
        @(negedge clk);
        if (ctr) begin
            if (resp_cyc == 0) begin
                resp_target = (fixed_delay != 0) ? fixed_delay : $urandom_range(1, TO_LEN + 2);
                if (resp_target > TO_LEN)
                    to_tally++;
                len_q.push_back((resp_target > TO_LEN) ? TO_LEN : resp_target);
            end
            resp_cyc++;
            trng_oe = (resp_cyc == resp_target);
        end else begin
            resp_cyc = 0;
            trng_oe  = 1'b0;
        end
    end

    initial forever begin
        @(negedge clk);
        if (uart_rand) begin
            uart_full  = ($urandom_range(0, 3) == 0);
            uart_empty = ($urandom_range(0, 2) == 0);
            uart_ready = ($urandom_range(0, 1) == 1);
        end else begin
            uart_full  = 1'b0;
            uart_empty = 1'b1;
            uart_ready = 1'b1;
        end
    end

    // Monitor: every oscillation start is a transaction carrying RO_SEL; every
    // end carries the oscillation length.
    initial forever begin
        @(negedge clk);
        if (ctr && !ctr_d) begin
            if (sel_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_osc: got oscillation at RO_SEL=%0d, expected none", ro_sel);
            end else begin
                check_output("ro_sel", int'(ro_sel), sel_q.pop_front());
            end
            len_meas = 1;
        end else if (ctr) begin
            len_meas++;
        end else if (ctr_d && len_q.size() != 0) begin
            exp_len = len_q.pop_front();
            if (len_chk)
                check_output("osc_len", len_meas, exp_len);
        end
        ctr_d = ctr;
    end

    task automatic apply_stimulus(input logic [SEL_W-1:0] b, input logic [SEL_W-1:0] e,
                                  input bit scramble);
        logic [SEL_W-1:0] s;
        int n;
        int cyc;
        s = e - b;
        n = int'(s) + 1;
        s = b;
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < SMP_PER_SEL; k++)
                sel_q.push_back(int'(s));
            s = s + 1'b1;
        end
        @(posedge clk);
        #1;
        to_tally  = 0;
        fixed     = 1'b0;
        sel_begin = b;
        sel_end   = e;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 0;
        while (!done && cyc < RUN_BOUND) begin
            @(negedge clk);
            cyc++;
            if (scramble && $urandom_range(0, 9) == 0) begin
                fixed     = 1'($urandom_range(0, 1));
                sel_begin = SEL_W'($urandom);
                sel_end   = SEL_W'($urandom);
            end
        end
        check_output("done_reached", int'(done), 1);
        check_output("samples_left", sel_q.size(), 0);
        check_output("final_ro_sel", int'(ro_sel), int'(e));
        check_output("to_cnt", int'(to_cnt), (to_tally > 255) ? 255 : to_tally);
        check_output("busy_in_fini", int'(busy), 0);
        sel_q.delete();
        fixed = 1'b0;
    endtask

    initial begin
        int cyc;
        bit saw_done;
        bit saw_idle;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_output("rst_ctr", int'(ctr), 0);
        check_output("rst_ro_sel", int'(ro_sel), 0);
        check_output("rst_busy", int'(busy), 0);
        check_output("rst_done", int'(done), 0);
        check_output("rst_to_cnt", int'(to_cnt), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] sweep 3..5, quiet UART, TRNG_OE on third cycle");
        fixed_delay = 3;
        uart_rand   = 1'b0;
        apply_stimulus(4'd3, 4'd5, 1'b0);

        $display("[TB] watchdog boundaries");
        fixed_delay = TO_LEN;
        apply_stimulus(4'd0, 4'd0, 1'b0);
        fixed_delay = TO_LEN + 1;
        apply_stimulus(4'd0, 4'd1, 1'b0);

        $display("[TB] wrap-around, single value and random sweeps");
        fixed_delay = 0;
        uart_rand   = 1'b1;
        apply_stimulus(4'd14, 4'd1, 1'b1);
        apply_stimulus(4'd9, 4'd9, 1'b1);
        for (int r = 0; r < 4; r++)
            apply_stimulus(SEL_W'($urandom), SEL_W'($urandom), 1'b1);

        $display("[TB] START and ABORT together from FINI");
        @(posedge clk);
        #1;
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        repeat (3) @(negedge clk);
        check_output("start_abort_busy", int'(busy), 0);
        check_output("start_abort_done", int'(done), 0);

        $display("[TB] fixed mode, 100 samples then ABORT");
        fixed_delay = 5;
        for (int i = 0; i < 100; i++)
            sel_q.push_back(7);
        @(posedge clk);
        #1;
        fixed     = 1'b1;
        sel_begin = 4'd7;
        sel_end   = 4'd2;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        saw_done = 1'b0;
        saw_idle = 1'b0;
        cyc = 0;
        while (sel_q.size() != 0 && cyc < RUN_BOUND) begin
            @(negedge clk);
            cyc++;
            saw_done |= done;
            saw_idle |= !busy;
            if ($urandom_range(0, 9) == 0) begin
                fixed     = 1'($urandom_range(0, 1));
                sel_begin = SEL_W'($urandom);
                sel_end   = SEL_W'($urandom);
            end
        end
        check_output("fixed_samples_left", sel_q.size(), 0);
        check_output("fixed_saw_done", int'(saw_done), 0);
        check_output("fixed_saw_idle", int'(saw_idle), 0);
        len_chk = 1'b0;
        @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        @(negedge clk);
        check_output("abort_ctr", int'(ctr), 0);
        check_output("abort_busy", int'(busy), 0);
        check_output("abort_ro_sel", int'(ro_sel), 7);
        check_output("abort_done", int'(done), 0);
        repeat (3) @(negedge clk);
        sel_q.delete();
        len_q.delete();
        len_chk = 1'b1;
        fixed   = 1'b0;

        $display("[TB] reset during oscillation, then a clean run");
        uart_rand   = 1'b0;
        fixed_delay = TO_LEN + 1;
        sel_q.push_back(3);
        sel_q.push_back(3);
        @(posedge clk);
        #1;
        sel_begin = 4'd3;
        sel_end   = 4'd5;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 0;
        while (sel_q.size() != 0 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check_output("pre_reset_ctr", int'(ctr), 1);
        check_output("pre_reset_to_cnt", int'(to_cnt), 1);
        len_chk = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_output("mid_rst_ctr", int'(ctr), 0);
        check_output("mid_rst_ro_sel", int'(ro_sel), 0);
        check_output("mid_rst_busy", int'(busy), 0);
        check_output("mid_rst_done", int'(done), 0);
        check_output("mid_rst_to_cnt", int'(to_cnt), 0);
        repeat (3) @(negedge clk);
        sel_q.delete();
        len_q.delete();
        len_chk     = 1'b1;
        fixed_delay = 0;
        uart_rand   = 1'b1;
        apply_stimulus(4'd5, 4'd8, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: got no completion within 90000 cycles, expected completion");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks + 1);
        $fatal(1, "[TB] simulation watchdog expired");
    end

endmodule
